control_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 104 ++++++++++
 rtl/ctrl_word_decode.sv | 112 +++++++++++
 rtl/control_sequencer.sv | 119 +++++++++++
 tb/tb_control_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// sequencer step encoding, control-word bit positions and opcode grouping.
package cpu_pkg;

    localparam int OPC_W = 5;
    localparam int ALU_W = 5;

    // Instruction opcodes (ir_out[31:27])
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // ALU function codes; register ops reuse their opcode as the ALU code
    localparam logic [ALU_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_SUB  = 5'b00100;
    localparam logic [ALU_W-1:0] ALU_AND  = 5'b00101;
    localparam logic [ALU_W-1:0] ALU_OR   = 5'b00110;

    // Sequencer steps
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    // Opcode groups that share an execute sequence
    typedef enum logic [2:0] {
        CL_REG  = 3'd0,
        CL_IMM  = 3'd1,
        CL_LDI  = 3'd2,
        CL_LD   = 3'd3,
        CL_ST   = 3'd4,
        CL_NOP  = 3'd5,
        CL_HALT = 3'd6
    } op_class_t;

    // Control-word bit positions
    localparam int CW_PCOUT   = 0;
    localparam int CW_ZLOWOUT = 1;
    localparam int CW_MDROUT  = 2;
    localparam int CW_COUT    = 3;
    localparam int CW_MARIN   = 4;
    localparam int CW_PCIN    = 5;
    localparam int CW_MDRIN   = 6;
    localparam int CW_IRIN    = 7;
    localparam int CW_YIN     = 8;
    localparam int CW_ZIN     = 9;
    localparam int CW_INCPC   = 10;
    localparam int CW_READ    = 11;
    localparam int CW_WRITE   = 12;
    localparam int CW_GRA     = 13;
    localparam int CW_GRB     = 14;
    localparam int CW_GRC     = 15;
    localparam int CW_RIN     = 16;
    localparam int CW_ROUT    = 17;
    localparam int CW_BAOUT   = 18;
    localparam int CW_DONE    = 19;
    localparam int CW_RUN     = 20;
    localparam int CW_W       = 21;

    // Map an opcode to its execute-sequence group; unknown codes behave as nop
    function automatic op_class_t classify(input logic [OPC_W-1:0] opc);
        op_class_t cls;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CL_REG;
            OP_ADDI, OP_ANDI, OP_ORI:      cls = CL_IMM;
            OP_LDI:                        cls = CL_LDI;
            OP_LD:                         cls = CL_LD;
            OP_ST:                         cls = CL_ST;
            OP_HALT:                       cls = CL_HALT;
            default:                       cls = CL_NOP;
        endcase
        return cls;
    endfunction

    // ALU function for the immediate forms
    function automatic logic [ALU_W-1:0] imm_alu(input logic [OPC_W-1:0] opc);
        logic [ALU_W-1:0] f;
        case (opc)
            OP_ANDI: f = ALU_AND;
            OP_ORI:  f = ALU_OR;
            default: f = ALU_ADD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Combinational decode of (sequencer step, opcode) into the control word
// and ALU function. No memory handshake input reaches this block.
module ctrl_word_decode
    import cpu_pkg::*;
(
    input  state_t             state_i,
    input  logic [OPC_W-1:0]   opcode_i,
    output logic [CW_W-1:0]    cw_o,
    output logic [ALU_W-1:0]   alu_op_o
);

    op_class_t op_class;
    assign op_class = classify(opcode_i);

    // Per-step strobe table; everything defaults low, run is high in T0..T7
    always_comb begin
        cw_o     = '0;
        alu_op_o = ALU_NONE;
        case (state_i)
            ST_T0: begin
                cw_o[CW_RUN]   = 1'b1;
                cw_o[CW_PCOUT] = 1'b1;
                cw_o[CW_MARIN] = 1'b1;
                cw_o[CW_INCPC] = 1'b1;
                cw_o[CW_ZIN]   = 1'b1;
            end
            ST_T1: begin
                cw_o[CW_RUN]     = 1'b1;
                cw_o[CW_ZLOWOUT] = 1'b1;
                cw_o[CW_PCIN]    = 1'b1;
                cw_o[CW_READ]    = 1'b1;
                cw_o[CW_MDRIN]   = 1'b1;
            end
            ST_T2: begin
                cw_o[CW_RUN]    = 1'b1;
                cw_o[CW_MDROUT] = 1'b1;
                cw_o[CW_IRIN]   = 1'b1;
            end
            ST_T3: begin
                cw_o[CW_RUN] = 1'b1;
                case (op_class)
                    CL_REG, CL_IMM: begin
                        cw_o[CW_GRB]  = 1'b1;
                        cw_o[CW_ROUT] = 1'b1;
                        cw_o[CW_YIN]  = 1'b1;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        cw_o[CW_GRB]   = 1'b1;
                        cw_o[CW_BAOUT] = 1'b1;
                        cw_o[CW_YIN]   = 1'b1;
                    end
                    CL_NOP:  cw_o[CW_DONE] = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                cw_o[CW_RUN] = 1'b1;
                cw_o[CW_ZIN] = 1'b1;
                case (op_class)
                    CL_REG: begin
                        cw_o[CW_GRC]  = 1'b1;
                        cw_o[CW_ROUT] = 1'b1;
                        alu_op_o      = opcode_i;
                    end
                    CL_IMM: begin
                        cw_o[CW_COUT] = 1'b1;
                        alu_op_o      = imm_alu(opcode_i);
                    end
                    default: begin
                        cw_o[CW_COUT] = 1'b1;
                        alu_op_o      = ALU_ADD;
                    end
                endcase
            end
            ST_T5: begin
                cw_o[CW_RUN]     = 1'b1;
                cw_o[CW_ZLOWOUT] = 1'b1;
                if (op_class == CL_LD || op_class == CL_ST) begin
                    cw_o[CW_MARIN] = 1'b1;
                end else begin
                    cw_o[CW_GRA]  = 1'b1;
                    cw_o[CW_RIN]  = 1'b1;
                    cw_o[CW_DONE] = 1'b1;
                end
            end
            ST_T6: begin
                cw_o[CW_RUN]   = 1'b1;
                cw_o[CW_MDRIN] = 1'b1;
                if (op_class == CL_ST) begin
                    // Read stays low so MDR captures the register from the bus
                    cw_o[CW_GRA]  = 1'b1;
                    cw_o[CW_ROUT] = 1'b1;
                end else begin
                    cw_o[CW_READ] = 1'b1;
                end
            end
            ST_T7: begin
                cw_o[CW_RUN]  = 1'b1;
                cw_o[CW_DONE] = 1'b1;
                if (op_class == CL_ST) begin
                    cw_o[CW_WRITE] = 1'b1;
                end else begin
                    cw_o[CW_MDROUT] = 1'b1;
                    cw_o[CW_GRA]    = 1'b1;
                    cw_o[CW_RIN]    = 1'b1;
                end
            end
            default: ; // RST and HALT drive nothing, run included
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer. The step register advances on
// each clock; memory steps (T1, ld-T6, st-T7) hold until mem_ready is seen
// high on the edge. Outputs depend only on the step and the IR opcode.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        clear_n,
    input  logic [31:0] ir_out,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op,
    output logic        instr_done,
    output logic        run,
    output logic [3:0]  dbg_state_o
);

    state_t            state_q;
    state_t            state_d;
    logic [OPC_W-1:0]  opcode;
    op_class_t         op_class;
    logic [CW_W-1:0]   cw;
    logic              unused_ir_bits;

    assign opcode         = ir_out[31:27];
    assign op_class       = classify(opcode);
    assign unused_ir_bits = ^ir_out[26:0];
    assign dbg_state_o    = state_q;

    // Step register; clear_n forces RST at any time
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next step: linear sequence with opcode branches at T3/T5 and memory holds
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  if (mem_ready) state_d = ST_T2;
            ST_T2:  state_d = ST_T3;
            ST_T3: begin
                case (op_class)
                    CL_HALT: state_d = ST_HALT;
                    CL_NOP:  state_d = ST_T0;
                    default: state_d = ST_T4;
                endcase
            end
            ST_T4:  state_d = ST_T5;
            ST_T5: begin
                if (op_class == CL_LD || op_class == CL_ST) state_d = ST_T6;
                else                                        state_d = ST_T0;
            end
            ST_T6: begin
                // ld waits for read data; st moves on once MDR is loaded
                if (op_class == CL_ST || mem_ready) state_d = ST_T7;
            end
            ST_T7: begin
                // st holds Write until memory accepts it
                if (op_class != CL_ST || mem_ready) state_d = ST_T0;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    ctrl_word_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .cw_o     (cw),
        .alu_op_o (alu_op)
    );

    assign PCout      = cw[CW_PCOUT];
    assign Zlowout    = cw[CW_ZLOWOUT];
    assign MDRout     = cw[CW_MDROUT];
    assign Cout       = cw[CW_COUT];
    assign MARin      = cw[CW_MARIN];
    assign PCin       = cw[CW_PCIN];
    assign MDRin      = cw[CW_MDRIN];
    assign IRin       = cw[CW_IRIN];
    assign Yin        = cw[CW_YIN];
    assign Zin        = cw[CW_ZIN];
    assign IncPC      = cw[CW_INCPC];
    assign Read       = cw[CW_READ];
    assign Write      = cw[CW_WRITE];
    assign Gra        = cw[CW_GRA];
    assign Grb        = cw[CW_GRB];
    assign Grc        = cw[CW_GRC];
    assign Rin        = cw[CW_RIN];
    assign Rout       = cw[CW_ROUT];
    assign BAout      = cw[CW_BAOUT];
    assign instr_done = cw[CW_DONE];
    assign run        = cw[CW_RUN];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Each instruction is expanded into the list of
// expected per-step output sets from the instruction table; memory steps
// carry a wait count during which mem_ready is held low.
module tb_control_sequencer;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic [31:0] ir_out = '0;
    logic        mem_ready = 1'b0;

    always #5 clock = ~clock;

    logic PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, instr_done, run;
    logic [4:0] alu_op;
    logic [3:0] dbg_state;

    control_sequencer dut (
        .clock(clock), .clear_n(clear_n), .ir_out(ir_out), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .instr_done(instr_done), .run(run),
        .dbg_state_o(dbg_state)
    );

    // Observed outputs packed in the bench's own order
    localparam int W = 26;
    logic [W-1:0] obs;
    assign obs = {run, instr_done, PCout, Zlowout, MDRout, Cout, MARin, PCin,
                  MDRin, IRin, Yin, Zin, IncPC, Read, Write, Gra, Grb, Grc,
                  Rin, Rout, BAout, alu_op};

    localparam logic [W-1:0] M_RUN  = 26'd1 << 25;
    localparam logic [W-1:0] M_DONE = 26'd1 << 24;
    localparam logic [W-1:0] M_PCO  = 26'd1 << 23;
    localparam logic [W-1:0] M_ZLO  = 26'd1 << 22;
    localparam logic [W-1:0] M_MDRO = 26'd1 << 21;
    localparam logic [W-1:0] M_CO   = 26'd1 << 20;
    localparam logic [W-1:0] M_MARI = 26'd1 << 19;
    localparam logic [W-1:0] M_PCI  = 26'd1 << 18;
    localparam logic [W-1:0] M_MDRI = 26'd1 << 17;
    localparam logic [W-1:0] M_IRI  = 26'd1 << 16;
    localparam logic [W-1:0] M_YI   = 26'd1 << 15;
    localparam logic [W-1:0] M_ZI   = 26'd1 << 14;
    localparam logic [W-1:0] M_INC  = 26'd1 << 13;
    localparam logic [W-1:0] M_RD   = 26'd1 << 12;
    localparam logic [W-1:0] M_WR   = 26'd1 << 11;
    localparam logic [W-1:0] M_GRA  = 26'd1 << 10;
    localparam logic [W-1:0] M_GRB  = 26'd1 << 9;
    localparam logic [W-1:0] M_GRC  = 26'd1 << 8;
    localparam logic [W-1:0] M_RIN  = 26'd1 << 7;
    localparam logic [W-1:0] M_ROUT = 26'd1 << 6;
    localparam logic [W-1:0] M_BA   = 26'd1 << 5;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           wait_q[$];   // -1: step never waits; n>=0: cycles of mem_ready low
    int           n_checks = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_excl(input string tag);
        n_checks++;
        assert ((Read & Write) === 1'b0) else begin
            n_err++;
            $error("FAIL %s_rd_wr_excl observed=%b expected=0", tag, Read & Write);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] alu(input logic [4:0] f);
        return {21'd0, f};
    endfunction

    task automatic push(input logic [W-1:0] e, input int w);
        exp_q.push_back(e | M_RUN);
        wait_q.push_back(w);
    endtask

    task automatic build_seq(input logic [4:0] opc, input int wmin, input int wmax);
        push(M_PCO | M_MARI | M_INC | M_ZI, -1);
        push(M_ZLO | M_PCI | M_RD | M_MDRI, $urandom_range(wmax, wmin));
        push(M_MDRO | M_IRI, -1);
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                push(M_GRB | M_ROUT | M_YI, -1);
                push(M_GRC | M_ROUT | M_ZI | alu(opc), -1);
                push(M_ZLO | M_GRA | M_RIN | M_DONE, -1);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push(M_GRB | M_ROUT | M_YI, -1);
                push(M_CO | M_ZI | alu(opc == 5'b01100 ? 5'b00011 :
                                       opc == 5'b01101 ? 5'b00101 : 5'b00110), -1);
                push(M_ZLO | M_GRA | M_RIN | M_DONE, -1);
            end
            5'b00001: begin
                push(M_GRB | M_BA | M_YI, -1);
                push(M_CO | M_ZI | alu(5'b00011), -1);
                push(M_ZLO | M_GRA | M_RIN | M_DONE, -1);
            end
            5'b00000: begin
                push(M_GRB | M_BA | M_YI, -1);
                push(M_CO | M_ZI | alu(5'b00011), -1);
                push(M_ZLO | M_MARI, -1);
                push(M_RD | M_MDRI, $urandom_range(wmax, wmin));
                push(M_MDRO | M_GRA | M_RIN | M_DONE, -1);
            end
            5'b00010: begin
                push(M_GRB | M_BA | M_YI, -1);
                push(M_CO | M_ZI | alu(5'b00011), -1);
                push(M_ZLO | M_MARI, -1);
                push(M_GRA | M_ROUT | M_MDRI, -1);
                push(M_WR | M_DONE, $urandom_range(wmax, wmin));
            end
            5'b11011: push('0, -1);
            default:  push(M_DONE, -1);
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Runs one instruction starting from the step before T0; abort_at stops
    // after that many checked cycles (leaving the DUT mid-instruction).
    task automatic run_instr(input logic [31:0] ir, input int wmin, input int wmax,
                             input int abort_at, input string tag);
        int cyc;
        cyc = 0;
        build_seq(ir[31:27], wmin, wmax);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            if (cyc == 0) ir_out = ir;
            if (wait_q[0] >= 0) mem_ready = (wait_q[0] == 0);
            else                mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk(tag, obs, exp_q[0]);
            chk_excl(tag);
            cyc++;
            if (wait_q[0] > 0) begin
                wait_q[0] = wait_q[0] - 1;
            end else begin
                void'(exp_q.pop_front());
                void'(wait_q.pop_front());
            end
            if (cyc == abort_at) begin
                exp_q.delete();
                wait_q.delete();
            end
        end
    endtask

    // Asynchronous reset mid-cycle, held one cycle, released on a falling edge
    task automatic do_reset(input string tag);
        #2 clear_n = 1'b0;
        #1 chk({tag, "_immediate"}, obs, '0);
        @(negedge clock);
        mem_ready = 1'b1;
        #1 chk({tag, "_hold"}, obs, '0);
        @(negedge clock);
        clear_n = 1'b1;
        #1 chk({tag, "_release"}, obs, '0);
    endtask

    logic [4:0] defined_ops [11];

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [4:0] opc;
        int k;
        defined_ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                        5'b00110, 5'b01100, 5'b01101, 5'b01110, 5'b11010};

        clear_n = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1 chk("reset_state", obs, '0);
        @(negedge clock);
        clear_n = 1'b1;
        #1 chk("reset_release_pre_edge", obs, '0);

        // add, zero-wait memory
        run_instr(32'h1A0A0000, 0, 0, -1, "add");
        // add aborted after its T4 cycle, then reset
        run_instr(32'h1A0A0000, 0, 0, 5, "add_to_t4");
        do_reset("rst_mid_t4");
        // T0 immediately after release, then ld with 3 waits at both memory steps
        run_instr({5'b00000, 27'h0123456}, 3, 3, -1, "ld_wait3");
        run_instr({5'b00010, 27'h0654321}, 2, 3, -1, "st_wait");
        run_instr({5'b00010, 27'h0000001}, 0, 0, -1, "st_nowait");
        run_instr({5'b01101, 27'h0000abc}, 0, 2, -1, "andi");
        run_instr({5'b01110, 27'h0000def}, 0, 2, -1, "ori");
        run_instr({5'b01100, 27'h0001234}, 0, 0, -1, "addi");
        run_instr({5'b00100, 27'h0000000}, 0, 1, -1, "sub");
        run_instr({5'b00101, 27'h7ffffff}, 0, 1, -1, "and");
        run_instr({5'b00110, 27'h5555555}, 0, 1, -1, "or");
        run_instr({5'b00001, 27'h2aaaaaa}, 0, 1, -1, "ldi");
        run_instr({5'b11010, 27'h0000000}, 0, 0, -1, "nop");
        // reset while ld waits in T1
        run_instr({5'b00000, 27'h0000000}, 6, 6, 3, "ld_to_t1_wait");
        do_reset("rst_mid_wait");

        // random instruction mix with random memory latency
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 12);
            if (k < 11) opc = defined_ops[k];
            else        opc = 5'($urandom_range(15, 25));
            run_instr({opc, 27'($urandom)}, 0, 3, -1, "random");
        end

        // undefined opcode behaves as nop, then halt
        run_instr({5'b11111, 27'h0000000}, 0, 1, -1, "undef_11111");
        run_instr({5'b11011, 27'h0000000}, 0, 1, -1, "halt");
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            ir_out = (i % 2 == 0) ? {5'b11111, 27'($urandom)} : $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            #1 chk("halt_hold", obs, '0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
